// File: rtl/melody_sequencer.sv
// Melody sequencer: steps through a programmable (note, duration) table and
// drives the sine generator note select with a restart pulse per entry.
module melody_sequencer #(
    parameter int AW       = 5,
    parameter int DUR_W    = 8,
    parameter int TICK_DIV = 1000,
    parameter int GAP_CYC  = 16
) (
    input  logic             clk_sine,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [3:0]       wr_note,
    input  logic [DUR_W-1:0] wr_dur,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    output logic [3:0]       frequency,
    output logic             note_start,
    output logic             playing,
    output logic             done,
    output logic [AW-1:0]    cur_idx
);

    localparam int DEPTH = 2 ** AW;
    localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [TW-1:0] TICK_LOAD = TW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GAP_LOAD  = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [3:0]    NOTE_END  = 4'hF;

    typedef enum logic [1:0] {IDLE, FETCH, PLAY, GAP} state_t;

    state_t           state;
    logic [3:0]       tbl_note [DEPTH];
    logic [DUR_W-1:0] tbl_dur  [DEPTH];
    logic [TW-1:0]    tick;
    logic [DUR_W-1:0] beat;
    logic [GW-1:0]    gcnt;
    logic             wrapped;
    logic [3:0]       rd_note;
    logic [DUR_W-1:0] rd_dur;
    logic [AW:0]      idx_inc;

    // Table RAM is deliberately not reset; writes only land while idle.
    always_ff @(posedge clk_sine) begin
        if (wr_en && state == IDLE) begin
            tbl_note[wr_addr] <= wr_note;
            tbl_dur[wr_addr]  <= wr_dur;
        end
    end

    assign rd_note = tbl_note[cur_idx];
    assign rd_dur  = tbl_dur[cur_idx];
    assign idx_inc = {1'b0, cur_idx} + 1'b1;

    always_ff @(posedge clk_sine) begin
        if (reset) begin
            state      <= IDLE;
            frequency  <= '0;
            note_start <= 1'b0;
            playing    <= 1'b0;
            done       <= 1'b0;
            cur_idx    <= '0;
            tick       <= '0;
            beat       <= '0;
            gcnt       <= '0;
            wrapped    <= 1'b0;
        end else begin
            note_start <= 1'b0;
            done       <= 1'b0;
            if (stop) begin
                state     <= IDLE;
                frequency <= '0;
                playing   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        frequency <= '0;
                        if (start) begin
                            state   <= FETCH;
                            playing <= 1'b1;
                            cur_idx <= '0;
                            wrapped <= 1'b0;
                        end
                    end
                    FETCH: begin
                        // A wrap past the last entry counts as END; END at index 0 never loops.
                        if (rd_note == NOTE_END || wrapped) begin
                            if (loop_en && cur_idx != '0) begin
                                cur_idx <= '0;
                                wrapped <= 1'b0;
                            end else begin
                                state   <= IDLE;
                                playing <= 1'b0;
                                done    <= 1'b1;
                            end
                        end else if (rd_dur == '0) begin
                            cur_idx <= idx_inc[AW-1:0];
                            wrapped <= idx_inc[AW];
                        end else begin
                            state      <= PLAY;
                            frequency  <= rd_note[3] ? 4'd0 : rd_note;
                            note_start <= 1'b1;
                            beat       <= rd_dur;
                            tick       <= TICK_LOAD;
                        end
                    end
                    PLAY: begin
                        if (tick == '0) begin
                            if (beat == DUR_W'(1)) begin
                                frequency <= '0;
                                cur_idx   <= idx_inc[AW-1:0];
                                wrapped   <= idx_inc[AW];
                                if (GAP_CYC > 0) begin
                                    state <= GAP;
                                    gcnt  <= GAP_LOAD;
                                end else begin
                                    state <= FETCH;
                                end
                            end else begin
                                tick <= TICK_LOAD;
                                beat <= beat - 1'b1;
                            end
                        end else begin
                            tick <= tick - 1'b1;
                        end
                    end
                    GAP: begin
                        if (gcnt == '0) state <= FETCH;
                        else            gcnt  <= gcnt - 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer: a behavioural walk of a shadow table
// queues the expected per-cycle outputs, which are popped and compared each cycle.
module tb_melody_sequencer;

    typedef struct packed {
        logic [3:0] f;
        logic       ns;
        logic       dn;
        logic       pl;
        logic [2:0] ix;
    } exp_t;

    logic       clk_sine = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_note;
    logic [7:0] wr_dur;
    logic       start;
    logic       stop;
    logic       loop_en;
    logic [3:0] frequency;
    logic       note_start;
    logic       playing;
    logic       done;
    logic [2:0] cur_idx;

    exp_t       q[$];
    int         total = 0;
    int         bad   = 0;
    int         sh_note [8];
    int         sh_dur  [8];
    logic [2:0] m_idx;

    melody_sequencer #(.AW(3), .DUR_W(8), .TICK_DIV(4), .GAP_CYC(2)) dut (
        .clk_sine(clk_sine), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_note(wr_note), .wr_dur(wr_dur), .start(start), .stop(stop),
        .loop_en(loop_en), .frequency(frequency), .note_start(note_start),
        .playing(playing), .done(done), .cur_idx(cur_idx)
    );

    always #5 clk_sine = ~clk_sine;

    task automatic push(input logic [3:0] f, input logic ns, input logic dn,
                        input logic pl, input logic [2:0] ix);
        exp_t e;
        e.f = f; e.ns = ns; e.dn = dn; e.pl = pl; e.ix = ix;
        q.push_back(e);
    endtask

    task automatic check(input string tag);
        exp_t e;
        exp_t o;
        e = q.pop_front();
        o = {frequency, note_start, done, playing, cur_idx};
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s step=%0d obs{f,ns,done,play,idx}=%h exp=%h", tag, total, o, e);
        end
    endtask

    task automatic drain_n(input string tag, input int n);
        for (int k = 0; k < n && q.size() > 0; k++) begin
            @(negedge clk_sine);
            start = 1'b0;
            stop  = 1'b0;
            check(tag);
        end
    endtask

    task automatic drain(input string tag);
        drain_n(tag, 100000);
    endtask

    task automatic wr(input int a, input int n, input int d);
        wr_en   = 1'b1;
        wr_addr = 3'(a);
        wr_note = 4'(n);
        wr_dur  = 8'(d);
        sh_note[a] = n;
        sh_dur[a]  = d;
        @(negedge clk_sine);
        wr_en = 1'b0;
    endtask

    // Walk the shadow table from index 0; stop before playing note number maxn.
    task automatic build(input bit lp, input int maxn);
        logic       m_wr;
        logic [3:0] t;
        logic [3:0] f;
        int         played;
        m_idx  = 3'd0;
        m_wr   = 1'b0;
        played = 0;
        push(4'd0, 1'b0, 1'b0, 1'b1, m_idx);
        for (int s = 0; s < 64; s++) begin
            if (sh_note[m_idx] == 15 || m_wr) begin
                if (lp && m_idx != 3'd0) begin
                    m_idx = 3'd0;
                    m_wr  = 1'b0;
                    push(4'd0, 1'b0, 1'b0, 1'b1, m_idx);
                    continue;
                end
                push(4'd0, 1'b0, 1'b1, 1'b0, m_idx);
                push(4'd0, 1'b0, 1'b0, 1'b0, m_idx);
                return;
            end
            if (sh_dur[m_idx] == 0) begin
                t = {1'b0, m_idx} + 4'd1;
                m_wr = t[3]; m_idx = t[2:0];
                push(4'd0, 1'b0, 1'b0, 1'b1, m_idx);
                continue;
            end
            if (played == maxn) return;
            f = (sh_note[m_idx] >= 8) ? 4'd0 : 4'(sh_note[m_idx]);
            for (int c = 0; c < sh_dur[m_idx] * 4; c++)
                push(f, c == 0, 1'b0, 1'b1, m_idx);
            played++;
            t = {1'b0, m_idx} + 4'd1;
            m_wr = t[3]; m_idx = t[2:0];
            push(4'd0, 1'b0, 1'b0, 1'b1, m_idx);
            push(4'd0, 1'b0, 1'b0, 1'b1, m_idx);
            push(4'd0, 1'b0, 1'b0, 1'b1, m_idx);
        end
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_note = '0; wr_dur = '0;
        start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        repeat (3) @(negedge clk_sine);
        push(4'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        drain("reset_state");
        reset = 1'b0;

        // 1: C for 2 beats, E for 1, END
        wr(0, 2, 2); wr(1, 6, 1); wr(2, 15, 0);
        start = 1'b1; build(1'b0, 99); drain("t1_song");

        // 2: looping returns to C without done, then stop mid-note
        loop_en = 1'b1;
        start = 1'b1; build(1'b1, 2); drain("t2_loop");
        push(4'd2, 1'b1, 1'b0, 1'b1, 3'd0);
        push(4'd2, 1'b0, 1'b0, 1'b1, 3'd0);
        push(4'd2, 1'b0, 1'b0, 1'b1, 3'd0);
        drain("t2_replay_c");
        stop = 1'b1;
        push(4'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        push(4'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        drain("t2_stop");
        loop_en = 1'b0;

        // 3: zero-duration entry is skipped
        wr(0, 4, 0); wr(1, 7, 1); wr(2, 15, 0);
        start = 1'b1; build(1'b0, 99); drain("t3_skip");

        // 4: full table without END wraps and finishes; entry 5 is a pause code
        for (int a = 0; a < 8; a++) wr(a, (a == 5) ? 9 : 3, 1);
        start = 1'b1; build(1'b0, 99); drain("t4_wrap");

        // 5: END at index 0 finishes even with loop_en
        wr(0, 15, 0);
        loop_en = 1'b1;
        start = 1'b1; build(1'b1, 99); drain("t5_end0");
        loop_en = 1'b0;

        // 6: reset mid-play, write during play ignored, start+stop ignored
        wr(0, 2, 2); wr(1, 6, 1); wr(2, 15, 0);
        start = 1'b1; build(1'b0, 99); drain_n("t6_pre", 5);
        q.delete();
        reset = 1'b1;
        push(4'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        drain("t6_reset");
        reset = 1'b0;
        start = 1'b1; build(1'b0, 99); drain_n("t6_play", 3);
        wr_en = 1'b1; wr_addr = 3'd0; wr_note = 4'd7; wr_dur = 8'd3;
        drain_n("t6_wr_busy", 2);
        wr_en = 1'b0;
        drain("t6_play_end");
        start = 1'b1; build(1'b0, 99); drain("t6_readback");
        start = 1'b1; stop = 1'b1;
        push(4'd0, 1'b0, 1'b0, 1'b0, m_idx);
        push(4'd0, 1'b0, 1'b0, 1'b0, m_idx);
        drain("t6_start_stop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
